pd_motor_mixer: RTL and testbench



---
 rtl/pd_motor_mixer.sv | 135 +++++++++++++
 tb/tb_pd_motor_mixer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pd_motor_mixer.sv
// Four-motor mixer: combines pitch/roll/yaw PD terms with thrust through one
// shared add/saturate datapath stepped over FRNT, BCK, LFT, RGHT.
module pd_motor_mixer #(
    parameter logic [10:0] MIN_RUN_SPEED = 11'd677,
    parameter logic [10:0] CAL_SPEED     = 11'd432,
    parameter int          SPD_W         = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic             inertial_cal,
    input  logic [8:0]       thrst,
    input  logic [9:0]       ptch_pterm,
    input  logic [11:0]      ptch_dterm,
    input  logic [9:0]       roll_pterm,
    input  logic [11:0]      roll_dterm,
    input  logic [9:0]       yaw_pterm,
    input  logic [11:0]      yaw_dterm,
    output logic [SPD_W-1:0] frnt_spd,
    output logic [SPD_W-1:0] bck_spd,
    output logic [SPD_W-1:0] lft_spd,
    output logic [SPD_W-1:0] rght_spd,
    output logic             spd_vld,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, FRNT, BCK, LFT, RGHT} state_t;

    // Handshake: vld is a request sampled only in IDLE; it is dropped (never
    // queued) while busy, and spd_vld is a one-cycle strobe on commit.
    state_t state;

    logic        cal_q;
    logic [8:0]  thrst_q;
    logic [9:0]  ptch_p_q, roll_p_q, yaw_p_q;
    logic [11:0] ptch_d_q, roll_d_q, yaw_d_q;
    logic [SPD_W-1:0] frnt_w, bck_w, lft_w, rght_w;

    logic signed [13:0] p_sum, r_sum, y_sum, base, raw;
    logic [SPD_W-1:0]   sat;

    always_comb begin
        p_sum = {{4{ptch_p_q[9]}}, ptch_p_q} + {{2{ptch_d_q[11]}}, ptch_d_q};
        r_sum = {{4{roll_p_q[9]}}, roll_p_q} + {{2{roll_d_q[11]}}, roll_d_q};
        y_sum = {{4{yaw_p_q[9]}}, yaw_p_q} + {{2{yaw_d_q[11]}}, yaw_d_q};
        base  = {3'b000, MIN_RUN_SPEED} + {5'b00000, thrst_q};
        raw   = '0;
        case (state)
            FRNT:    raw = base - p_sum - y_sum;
            BCK:     raw = base + p_sum - y_sum;
            LFT:     raw = base + r_sum + y_sum;
            RGHT:    raw = base - r_sum + y_sum;
            default: raw = '0;
        endcase
    end

    // Clamp the shared result to the unsigned 11-bit motor range.
    always_comb begin
        sat = '0;
        if (cal_q)
            sat = CAL_SPEED;
        else if (raw[13])
            sat = '0;
        else if (raw > 14'sd2047)
            sat = 11'h7FF;
        else
            sat = raw[10:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cal_q    <= 1'b0;
            thrst_q  <= '0;
            ptch_p_q <= '0;
            ptch_d_q <= '0;
            roll_p_q <= '0;
            roll_d_q <= '0;
            yaw_p_q  <= '0;
            yaw_d_q  <= '0;
            frnt_w   <= '0;
            bck_w    <= '0;
            lft_w    <= '0;
            rght_w   <= '0;
            frnt_spd <= '0;
            bck_spd  <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (vld) begin
                        cal_q    <= inertial_cal;
                        thrst_q  <= thrst;
                        ptch_p_q <= ptch_pterm;
                        ptch_d_q <= ptch_dterm;
                        roll_p_q <= roll_pterm;
                        roll_d_q <= roll_dterm;
                        yaw_p_q  <= yaw_pterm;
                        yaw_d_q  <= yaw_dterm;
                        state    <= FRNT;
                    end
                end
                FRNT: begin
                    frnt_w <= sat;
                    state  <= BCK;
                end
                BCK: begin
                    bck_w <= sat;
                    state <= LFT;
                end
                LFT: begin
                    lft_w <= sat;
                    state <= RGHT;
                end
                RGHT: begin
                    // All four speeds commit together, including this cycle's result.
                    rght_w   <= sat;
                    frnt_spd <= frnt_w;
                    bck_spd  <= bck_w;
                    lft_spd  <= lft_w;
                    rght_spd <= sat;
                    spd_vld  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pd_motor_mixer.sv
// Bench for pd_motor_mixer: integer reference model feeding an expected queue,
// popped and compared whenever the mixer commits.
module tb_pd_motor_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic        inertial_cal;
    logic [8:0]  thrst;
    logic [9:0]  ptch_pterm, roll_pterm, yaw_pterm;
    logic [11:0] ptch_dterm, roll_dterm, yaw_dterm;
    logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
    logic        spd_vld;
    logic        busy;

    logic [43:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pd_motor_mixer dut (
        .clk(clk), .rst(rst), .vld(vld), .inertial_cal(inertial_cal),
        .thrst(thrst), .ptch_pterm(ptch_pterm), .ptch_dterm(ptch_dterm),
        .roll_pterm(roll_pterm), .roll_dterm(roll_dterm),
        .yaw_pterm(yaw_pterm), .yaw_dterm(yaw_dterm),
        .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd),
        .rght_spd(rght_spd), .spd_vld(spd_vld), .busy(busy)
    );

    function automatic logic [10:0] clamp(input int v);
        if (v < 0) return 11'd0;
        if (v > 2047) return 11'd2047;
        return v[10:0];
    endfunction

    function automatic logic [43:0] model(input logic cal, input int thr,
        input int pp, input int pd, input int rp, input int rd, input int yp, input int yd);
        int b, p, r, y;
        if (cal) return {11'd432, 11'd432, 11'd432, 11'd432};
        b = 677 + thr;
        p = pp + pd;
        r = rp + rd;
        y = yp + yd;
        return {clamp(b - p - y), clamp(b + p - y), clamp(b + r + y), clamp(b - r + y)};
    endfunction

    task automatic drive(input logic cal, input int thr,
        input int pp, input int pd, input int rp, input int rd, input int yp, input int yd);
        inertial_cal = cal;
        thrst        = thr[8:0];
        ptch_pterm   = pp[9:0];
        ptch_dterm   = pd[11:0];
        roll_pterm   = rp[9:0];
        roll_dterm   = rd[11:0];
        yaw_pterm    = yp[9:0];
        yaw_dterm    = yd[11:0];
    endtask

    // Drive one request at a negedge; return at the negedge after the capture edge.
    task automatic send(input logic cal, input int thr,
        input int pp, input int pd, input int rp, input int rd, input int yp, input int yd);
        @(negedge clk);
        drive(cal, thr, pp, pd, rp, rd, yp, yd);
        vld = 1'b1;
        exp_q.push_back(model(cal, thr, pp, pd, rp, rd, yp, yd));
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic wait_commit(output int edges, output int busy_cnt);
        int cycles = 1;
        busy_cnt = 0;
        while (!spd_vld && cycles < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        edges = cycles - 1;
    endtask

    task automatic check_one_commit(input string name);
        int edges, bc;
        logic [43:0] exp_v, got;
        wait_commit(edges, bc);
        n_checks++;
        if (edges !== 4) begin
            n_fail++;
            $display("FAIL %s latency: got %0d edges, expected 4", name, edges);
        end
        n_checks++;
        if (bc !== 4) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d, expected 4", name, bc);
        end
        got = {frnt_spd, bck_spd, lft_spd, rght_spd};
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 44'hX;
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s speeds: got f=%0d b=%0d l=%0d r=%0d, expected f=%0d b=%0d l=%0d r=%0d",
                     name, got[43:33], got[32:22], got[21:11], got[10:0],
                     exp_v[43:33], exp_v[32:22], exp_v[21:11], exp_v[10:0]);
        end
        @(negedge clk);
        n_checks++;
        if (spd_vld !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse_end: got spd_vld=%b busy=%b, expected 0 0", name, spd_vld, busy);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        vld = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_state: got f=%0d b=%0d l=%0d r=%0d vld=%b busy=%b, expected all 0",
                     frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        send(1'b0, 0, 0, 0, 0, 0, 0, 0);
        check_one_commit("idle_speed");
        send(1'b0, 0, 10, 20, 0, 0, 0, 0);
        check_one_commit("pitch");
        send(1'b0, 0, 0, 0, 0, 0, -5, -5);
        check_one_commit("yaw");
        send(1'b0, 100, -37, 150, 22, -400, 3, 60);
        check_one_commit("mixed");
    endtask

    task automatic test_saturation;
        send(1'b0, 511, 0, 2047, 0, 0, 0, 0);
        check_one_commit("sat_pitch");
        send(1'b0, 0, 0, 0, -512, -2048, 0, 0);
        check_one_commit("sat_roll");
    endtask

    task automatic test_cal;
        send(1'b1, 300, 100, -200, 50, 60, -70, 80);
        check_one_commit("cal");
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            send(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 511)),
                 int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 1023)) - 512, int'($urandom_range(0, 4095)) - 2048);
            check_one_commit("random");
        end
    endtask

    task automatic test_back_to_back;
        int last, cnt;
        logic [43:0] exp_v;
        @(negedge clk);
        drive(1'b0, 40, 5, 6, 7, 8, 9, 10);
        for (int k = 0; k < 3; k++) exp_q.push_back(model(1'b0, 40, 5, 6, 7, 8, 9, 10));
        vld  = 1'b1;
        last = 0;
        cnt  = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (spd_vld) begin
                cnt++;
                n_checks++;
                if (i - last !== 5) begin
                    n_fail++;
                    $display("FAIL b2b_spacing: got %0d cycles, expected 5", i - last);
                end
                last = i;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 44'hX;
                n_checks++;
                if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== exp_v) begin
                    n_fail++;
                    $display("FAIL b2b_speeds: got %h, expected %h",
                             {frnt_spd, bck_spd, lft_spd, rght_spd}, exp_v);
                end
            end
        end
        vld = 1'b0;
        n_checks++;
        if (cnt !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d commits, expected 3", cnt);
        end
        repeat (6) @(negedge clk);
        // Mid-sequence vld pulse and input change during BCK must not disturb this commit.
        send(1'b0, 200, 30, -40, 0, 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 5, 1, 1, 1, 1, 1, 1);
        vld = 1'b1;
        @(negedge clk);
        vld = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (spd_vld) begin
                cnt++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 44'hX;
                n_checks++;
                if ({frnt_spd, bck_spd, lft_spd, rght_spd} !== exp_v) begin
                    n_fail++;
                    $display("FAIL busy_ignore_speeds: got %h, expected %h",
                             {frnt_spd, bck_spd, lft_spd, rght_spd}, exp_v);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (cnt !== 1) begin
            n_fail++;
            $display("FAIL busy_ignore_count: got %0d commits, expected 1", cnt);
        end
    endtask

    task automatic test_reset_mid;
        int cnt = 0;
        logic [43:0] dropped;
        send(1'b0, 50, 11, 12, 13, 14, 15, 16);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got f=%0d b=%0d l=%0d r=%0d vld=%b busy=%b, expected all 0",
                     frnt_spd, bck_spd, lft_spd, rght_spd, spd_vld, busy);
        end
        dropped = exp_q.pop_back();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (spd_vld || busy) cnt++;
        end
        n_checks++;
        if (cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, expected 0 (dropped %h)", cnt, dropped);
        end
        send(1'b0, 0, 0, 0, 10, 20, 0, 0);
        check_one_commit("after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_cal();
        test_random();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL queue_empty: got %0d leftover, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
